// File: rtl/systolic_pkg.sv
// Shared types, default widths and saturation bounds for the systolic MAC PE.
// The bound helpers return ACC_W_MAX-bit values; callers size-cast them to their own width.
package systolic_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int ACC_W_MAX  = 64;

  typedef enum logic {
    ACC,
    DRAIN
  } drain_state_t;

  // Largest representable accumulator value for the given width and signedness.
  function automatic logic [ACC_W_MAX-1:0] max_acc(input int width, input bit is_signed);
    logic [ACC_W_MAX-1:0] ones;
    ones = '1;
    return is_signed ? (ones >> (ACC_W_MAX - width + 1)) : (ones >> (ACC_W_MAX - width));
  endfunction

  // Smallest representable accumulator value; the low `width` bits are the pattern to load.
  function automatic logic [ACC_W_MAX-1:0] min_acc(input int width, input bit is_signed);
    logic [ACC_W_MAX-1:0] ones;
    ones = '1;
    return is_signed ? (ones << (width - 1)) : '0;
  endfunction

endpackage

// File: rtl/systolic_mac_core.sv
// Accumulator datapath of the systolic PE: product extension, clear/add and ovf.
// Macro SYSTOLIC_PE_SAT_EN switches accumulation from wrapping to saturating.
module systolic_mac_core
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              fire,
  input  logic              clr_in,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    acc_nxt;

  // Operands are pre-extended to the full product width so the multiply is self-sized.
  if (SIGNED != 0) begin : g_signed_prod
    assign prod     = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in})
                    * $signed({{DATA_W{b_in[DATA_W-1]}}, b_in});
    assign prod_ext = ACC_W'($signed(prod));
  end else begin : g_unsigned_prod
    assign prod     = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
    assign prod_ext = ACC_W'(prod);
  end

`ifdef SYSTOLIC_PE_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(max_acc(ACC_W, SIGNED != 0));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(min_acc(ACC_W, SIGNED != 0));

  logic [ACC_W:0]   sum_wide;
  logic             add_ovf;
  logic [ACC_W-1:0] sat_val;

  // Signed overflow: both addends share a sign that the result lost; the clamp follows that sign.
  always_comb begin
    sum_wide = {1'b0, acc} + {1'b0, prod_ext};
    if (SIGNED != 0) begin
      add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_wide[ACC_W-1] != acc[ACC_W-1]);
      sat_val = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      add_ovf = sum_wide[ACC_W];
      sat_val = ACC_MAX;
    end
    sum = add_ovf ? sat_val : sum_wide[ACC_W-1:0];
  end

  // The product always fits in ACC_W, so only the accumulate path can clamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (fire && !clr_in && add_ovf) begin
      ovf <= 1'b1;
    end
  end
`else
  assign sum = acc + prod_ext;
  assign ovf = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    acc_nxt = acc;
    if (clr_in) begin
      acc_nxt = fire ? prod_ext : '0;
    end else if (fire) begin
      acc_nxt = sum;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC processing element: operand forwarding, protocol
// error flag and the column drain chain. Optional macro: SYSTOLIC_PE_SAT_EN.
module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  input  logic              clr_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic              clr_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  input  logic              drain_in,
  input  logic [ACC_W-1:0]  res_in,
  input  logic              res_vld_in,
  output logic [ACC_W-1:0]  res_out,
  output logic              res_vld_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              err,
  output logic              ovf
);

  logic             fire;
  logic [ACC_W-1:0] acc;
  drain_state_t     state;
  drain_state_t     state_nxt;
  logic [ACC_W-1:0] res_nxt;
  logic             res_vld_nxt;

  assign fire    = a_vld_in & b_vld_in;
  assign acc_out = acc;

  systolic_mac_core #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .a_in   (a_in),
    .b_in   (b_in),
    .fire   (fire),
    .clr_in (clr_in),
    .acc    (acc),
    .ovf    (ovf)
  );

  // Operands and markers forward unconditionally; valid travels alongside as plain data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      clr_out   <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      clr_out   <= clr_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
    end
  end

  // A lone valid means the neighbours are out of step; the flag stays up until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (a_vld_in ^ b_vld_in) begin
      err <= 1'b1;
    end
  end

  // Drain captures acc before this cycle's update, so a new tile may clear/start alongside it.
  always_comb begin
    state_nxt   = state;
    res_nxt     = res_out;
    res_vld_nxt = 1'b0;
    unique case (state)
      ACC: begin
        if (drain_in) begin
          res_nxt     = acc;
          res_vld_nxt = 1'b1;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        res_nxt     = res_in;
        res_vld_nxt = res_vld_in;
        if (!res_vld_in) begin
          state_nxt = ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACC;
      res_out     <= '0;
      res_vld_out <= 1'b0;
    end else begin
      state       <= state_nxt;
      res_out     <= res_nxt;
      res_vld_out <= res_vld_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: a 4-deep unsigned column, one signed PE and one 16-bit PE.
module tb_systolic_mac_pe;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int WW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Column of unsigned PEs, index 0 at the top.
  logic [DW-1:0] col_a      [N];
  logic          col_a_vld  [N];
  logic [DW-1:0] col_b      [N];
  logic          col_b_vld  [N];
  logic          col_clr    [N];
  logic [DW-1:0] col_a_out  [N];
  logic          col_av_out [N];
  logic          col_clr_out[N];
  logic [DW-1:0] col_b_out  [N];
  logic          col_bv_out [N];
  logic [AW-1:0] col_acc    [N];
  logic          col_err    [N];
  logic          col_ovf    [N];
  logic [AW-1:0] res_chain  [N+1];
  logic          rvld_chain [N+1];
  logic          drain;

  assign res_chain[0]  = '0;
  assign rvld_chain[0] = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_col
    systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(0)) u_pe (
      .clk(clk), .rst(rst),
      .a_in(col_a[g]), .a_vld_in(col_a_vld[g]),
      .b_in(col_b[g]), .b_vld_in(col_b_vld[g]),
      .clr_in(col_clr[g]),
      .a_out(col_a_out[g]), .a_vld_out(col_av_out[g]), .clr_out(col_clr_out[g]),
      .b_out(col_b_out[g]), .b_vld_out(col_bv_out[g]),
      .drain_in(drain),
      .res_in(res_chain[g]), .res_vld_in(rvld_chain[g]),
      .res_out(res_chain[g+1]), .res_vld_out(rvld_chain[g+1]),
      .acc_out(col_acc[g]), .err(col_err[g]), .ovf(col_ovf[g])
    );
  end

  // Signed PE.
  logic [DW-1:0] s_a, s_b, s_a_out, s_b_out;
  logic          s_a_vld, s_b_vld, s_clr, s_av_out, s_bv_out, s_clr_out;
  logic [AW-1:0] s_res_out, s_acc;
  logic          s_res_vld, s_err, s_ovf;

  systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1)) u_signed (
    .clk(clk), .rst(rst),
    .a_in(s_a), .a_vld_in(s_a_vld), .b_in(s_b), .b_vld_in(s_b_vld), .clr_in(s_clr),
    .a_out(s_a_out), .a_vld_out(s_av_out), .clr_out(s_clr_out),
    .b_out(s_b_out), .b_vld_out(s_bv_out),
    .drain_in(1'b0), .res_in('0), .res_vld_in(1'b0),
    .res_out(s_res_out), .res_vld_out(s_res_vld),
    .acc_out(s_acc), .err(s_err), .ovf(s_ovf)
  );

  // Narrow-accumulator PE for the wrap / saturate boundary.
  logic [DW-1:0] w_a, w_b, w_a_out, w_b_out;
  logic          w_a_vld, w_b_vld, w_clr, w_av_out, w_bv_out, w_clr_out;
  logic [WW-1:0] w_res_out, w_acc;
  logic          w_res_vld, w_err, w_ovf;

  systolic_mac_pe #(.DATA_W(DW), .ACC_W(WW), .SIGNED(0)) u_wide (
    .clk(clk), .rst(rst),
    .a_in(w_a), .a_vld_in(w_a_vld), .b_in(w_b), .b_vld_in(w_b_vld), .clr_in(w_clr),
    .a_out(w_a_out), .a_vld_out(w_av_out), .clr_out(w_clr_out),
    .b_out(w_b_out), .b_vld_out(w_bv_out),
    .drain_in(1'b0), .res_in('0), .res_vld_in(1'b0),
    .res_out(w_res_out), .res_vld_out(w_res_vld),
    .acc_out(w_acc), .err(w_err), .ovf(w_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < N; k++) begin
      col_a_vld[k] = 1'b0;
      col_b_vld[k] = 1'b0;
      col_clr[k]   = 1'b0;
    end
    drain   = 1'b0;
    s_a_vld = 1'b0; s_b_vld = 1'b0; s_clr = 1'b0;
    w_a_vld = 1'b0; w_b_vld = 1'b0; w_clr = 1'b0;
  endtask

  // Scoreboard for the drain chain at the bottom of the column.
  logic [31:0] exp_q[$];
  int          vld_seen;

  always @(negedge clk) begin
    if (!rst && rvld_chain[N]) begin
      logic [31:0] exp_v;
      vld_seen++;
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("drain_res", 32'(res_chain[N]), exp_v);
    end
  end

  task automatic wait_drain_empty();
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
    check("drain_q_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] model;
    logic [7:0]  ra, rb;
    vld_seen = 0;
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      col_a[k] = '0;
      col_b[k] = '0;
    end
    s_a = '0; s_b = '0; w_a = '0; w_b = '0;
    idle();
    #2;
    check("rst_acc", 32'(col_acc[N-1]), 0);
    check("rst_res_vld", 32'(rvld_chain[N]), 0);
    check("rst_err", 32'(col_err[N-1]), 0);
    check("rst_a_out", 32'(col_a_out[N-1]), 0);
    tick();
    rst = 1'b0;

    // Basic unsigned MAC on the bottom PE: 2*3 four times, cleared on the first.
    for (int i = 0; i < 4; i++) begin
      col_a[3] = 8'd2; col_b[3] = 8'd3;
      col_a_vld[3] = 1'b1; col_b_vld[3] = 1'b1;
      col_clr[3] = (i == 0);
      tick();
      check("mac_acc", 32'(col_acc[3]), 32'(6 * (i + 1)));
      check("fwd_a", 32'(col_a_out[3]), 2);
      check("fwd_clr", 32'(col_clr_out[3]), (i == 0) ? 1 : 0);
    end
    check("fwd_b", 32'(col_b_out[3]), 3);
    check("fwd_bv", 32'(col_bv_out[3]), 1);

    // Data forwards even without valid; acc holds.
    idle();
    col_a[3] = 8'h5A; col_b[3] = 8'hC3;
    tick();
    check("fwd_a_novld", 32'(col_a_out[3]), 32'h5A);
    check("fwd_av_novld", 32'(col_av_out[3]), 0);
    check("fwd_b_novld", 32'(col_b_out[3]), 32'hC3);
    check("hold_acc", 32'(col_acc[3]), 24);
    check("no_err", 32'(col_err[3]), 0);

    // Lone a valid: no MAC, sticky err.
    col_a[3] = 8'd9; col_a_vld[3] = 1'b1;
    tick();
    idle();
    check("perr_acc", 32'(col_acc[3]), 24);
    check("perr_err", 32'(col_err[3]), 1);
    tick(); tick();
    check("perr_sticky", 32'(col_err[3]), 1);

    // Random MACs on PE2 against a wrapping model, with occasional idle cycles.
    model = 0;
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      col_a[2] = ra; col_b[2] = rb;
      col_a_vld[2] = (i % 4 != 3); col_b_vld[2] = (i % 4 != 3);
      col_clr[2] = (i == 0);
      if (i == 0) model = 32'(ra) * 32'(rb);
      else if (i % 4 != 3) model = (model + 32'(ra) * 32'(rb)) & 32'hFFFFF;
      tick();
      check("rand_acc", 32'(col_acc[2]), model);
    end
    idle();

    // Load 10,20,30,40 top to bottom.
    for (int k = 0; k < N; k++) begin
      col_a[k] = 8'(10 * (k + 1)); col_b[k] = 8'd1;
      col_a_vld[k] = 1'b1; col_b_vld[k] = 1'b1; col_clr[k] = 1'b1;
    end
    tick();
    idle();
    for (int k = 0; k < N; k++) check("col_load", 32'(col_acc[k]), 32'(10 * (k + 1)));

    // Drain with same-cycle clr+fire on the bottom PE; second drain cycle must be ignored.
    for (int k = N - 1; k >= 0; k--) exp_q.push_back(32'(10 * (k + 1)));
    vld_seen = 0;
    drain = 1'b1;
    col_a[3] = 8'd1; col_b[3] = 8'd1;
    col_a_vld[3] = 1'b1; col_b_vld[3] = 1'b1; col_clr[3] = 1'b1;
    tick();
    col_a_vld[3] = 1'b0; col_b_vld[3] = 1'b0; col_clr[3] = 1'b0;
    check("dbuf_acc", 32'(col_acc[3]), 1);
    tick();
    drain = 1'b0;
    wait_drain_empty();
    check("drain_vld_low", 32'(rvld_chain[N]), 0);
    check("drain_len", vld_seen, N);

    // Signed PE: -3*5 then +7*2, then the -128*-128 extreme.
    s_a = 8'hFD; s_b = 8'd5; s_a_vld = 1'b1; s_b_vld = 1'b1; s_clr = 1'b1;
    tick();
    check("s_neg", 32'(s_acc), 32'hFFFF1);
    s_a = 8'd7; s_b = 8'd2; s_clr = 1'b0;
    tick();
    check("s_sum", 32'(s_acc), 32'hFFFFF);
    s_a = 8'h80; s_b = 8'h80; s_clr = 1'b1;
    tick();
    check("s_minsq", 32'(s_acc), 32'h04000);
    s_a = 8'h80; s_b = 8'h7F; s_clr = 1'b1;
    tick();
    check("s_minmax", 32'(s_acc), 32'hFC080);
    idle();

    // 16-bit PE: 65000 + 255*255 wraps, or clamps when saturation is built in.
    w_a = 8'd255; w_b = 8'd254; w_a_vld = 1'b1; w_b_vld = 1'b1; w_clr = 1'b1;
    tick();
    w_a = 8'd230; w_b = 8'd1; w_clr = 1'b0;
    tick();
    check("w_65000", 32'(w_acc), 65000);
    check("w_ovf_pre", 32'(w_ovf), 0);
    w_a = 8'd255; w_b = 8'd255;
    tick();
    idle();
`ifdef SYSTOLIC_PE_SAT_EN
    check("w_sat", 32'(w_acc), 65535);
    check("w_ovf", 32'(w_ovf), 1);
    tick();
    check("w_ovf_sticky", 32'(w_ovf), 1);
`else
    check("w_wrap", 32'(w_acc), 64489);
    check("w_ovf", 32'(w_ovf), 0);
    tick();
    check("w_ovf_idle", 32'(w_ovf), 0);
`endif

    // Asynchronous reset in the middle of a drain.
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd30);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd10);
    drain = 1'b1;
    tick();
    drain = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    check("arst_res", 32'(res_chain[N]), 0);
    check("arst_res_vld", 32'(rvld_chain[N]), 0);
    check("arst_acc", 32'(col_acc[2]), 0);
    check("arst_err", 32'(col_err[3]), 0);
    exp_q.delete();
    tick();
    rst = 1'b0;

    // Clean restart: load 5..8 and drain again.
    for (int k = 0; k < N; k++) begin
      col_a[k] = 8'(5 + k); col_b[k] = 8'd1;
      col_a_vld[k] = 1'b1; col_b_vld[k] = 1'b1; col_clr[k] = 1'b1;
    end
    tick();
    idle();
    for (int k = N - 1; k >= 0; k--) exp_q.push_back(32'(5 + k));
    vld_seen = 0;
    drain = 1'b1;
    tick();
    drain = 1'b0;
    wait_drain_empty();
    check("redrain_len", vld_seen, N);
    check("redrain_vld_low", 32'(rvld_chain[N]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_mac_pe.md
Name: systolic_mac_pe

Overview:
Parametrised processing element for the output-stationary systolic matrix-multiply array. It is the successor to the 8-bit Cell: configurable operand and accumulator widths, signed or unsigned arithmetic, and per-operand valid flags. It adds a clear marker that travels with the data, a shift-chain result drain, and a protocol-error flag. PEs tile an N×N array: a flows west→east, b flows north→south, and results drain south along each column.

Parameters:
DATA_W, 8, operand width (a, b)
ACC_W, 20, accumulator width; must be ≥ 2*DATA_W
SIGNED, 0, 1 = two's-complement operands and accumulator; 0 = unsigned

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
a_in  in  DATA_W  west operand
a_vld_in  in  1  a_in valid
b_in  in  DATA_W  north operand
b_vld_in  in  1  b_in valid
clr_in  in  1  start-of-tile marker, travels with a
a_out  out  DATA_W  registered a_in, to east neighbour
a_vld_out  out  1  registered a_vld_in
clr_out  out  1  registered clr_in
b_out  out  DATA_W  registered b_in, to south neighbour
b_vld_out  out  1  registered b_vld_in
drain_in  in  1  drain-start pulse, broadcast to the column in the same cycle
res_in  in  ACC_W  result from north neighbour (top PE: tie 0)
res_vld_in  in  1  res_in valid (top PE: tie 0)
res_out  out  ACC_W  drain chain output, to south neighbour
res_vld_out  out  1  res_out valid
acc_out  out  ACC_W  live accumulator value
err  out  1  sticky protocol error
ovf  out  1  sticky overflow (SAT_EN only; otherwise 0)

Behaviour:
- Reset: all outputs, the accumulator, and the result register go to 0. The FSM goes to ACC.
- Forwarding: a_out, a_vld_out, clr_out, b_out and b_vld_out equal their inputs delayed by exactly 1 cycle. Data forwards regardless of valid.
- fire = a_vld_in & b_vld_in.
- Product: the full 2*DATA_W product is formed, then sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W.
- Accumulator update, highest priority first:
  - clr_in & fire: acc ← product
  - clr_in & !fire: acc ← 0
  - fire: acc ← acc + product, wrapping mod 2^ACC_W
  - otherwise: hold
- acc_out mirrors acc; it is registered and has 1-cycle latency from fire.
- Protocol error: a_vld_in XOR b_vld_in sets err (sticky until rst). No MAC occurs in that cycle.
- Drain FSM, states ACC and DRAIN:
  - ACC, drain_in=1: res_out ← acc as it was before this cycle's update, res_vld_out ← 1, go to DRAIN. A MAC or clear in the same cycle still applies to acc. This is the double-buffer case: drain tile k while clearing and starting tile k+1.
  - DRAIN: res_out ← res_in and res_vld_out ← res_vld_in every cycle. If res_vld_in=0, return to ACC.
  - drain_in while in DRAIN: ignored.
  - Accumulation continues independently in both states.
- Column timing: after a drain pulse at cycle t, the bottom PE of an N-deep column emits its own accumulator at t+1, then the PE above it at t+2, and so on. res_vld_out is high for exactly N consecutive cycles.
- rst mid-drain: chain cleared immediately, FSM returns to ACC.

Optional Feature:
Macro SYSTOLIC_PE_SAT_EN.
- Defined: accumulate and clear-load saturate instead of wrapping.
  - SIGNED=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SIGNED=0: clamp to [0, 2^ACC_W-1].
  - Any clamp sets ovf, sticky until rst.
- Undefined: arithmetic wraps and ovf is tied to 0.

Decomposition:
- Package systolic_pkg:
  - drain_state_t enum {ACC, DRAIN}
  - default width constants DATA_W_DEF=8, ACC_W_DEF=20
  - saturation bound functions max_acc and min_acc, parametrised by width and signedness
- Sub-module systolic_mac_core holds the accumulator register, product extension, the add/clear/saturate logic, and ovf. The top level holds forwarding registers, err, and the drain FSM.

Test Plan:
- Defaults, SIGNED=0: a=2, b=3 with both valid for 4 cycles, clr on the first → acc_out=6, 12, 18, 24; a_out=2 one cycle after each a_in.
- SIGNED=1: a=-3 (0xFD), b=5, clr, then a=7, b=2 → acc_out=-15, then -1 (0xFFFFF).
- a_vld_in=1, b_vld_in=0, acc=24 → acc holds 24, err=1 and stays 1 until rst.
- 4-deep column with accs 10, 20, 30, 40 (top→bottom), drain pulse at t → bottom res_out = 40, 30, 20, 10 at t+1..t+4, res_vld_out low at t+5. Same-cycle clr+fire a=1, b=1 → acc=1 while 40 is drained.
- SAT_EN, SIGNED=0, ACC_W=16: acc=65000, add 255*255 → acc_out=65535, ovf=1. Without SAT_EN the same stimulus → acc_out=(65000+65025) mod 65536=64489, ovf=0.
- rst asserted asynchronously mid-drain (cycle t+2) → res_out, res_vld_out, acc_out, err all 0 before the next clk edge; next drain_in restarts cleanly.
